// File: rtl/rw_cmd_arbiter.sv
// Read/write address-FIFO command scheduler: read priority, bounded write starvation,
// bus-turnaround idle gap. Optional periodic refresh is enabled by defining REFRESH_EN.
module rw_cmd_arbiter #(
  parameter int AW         = 32,
  parameter int TURN       = 4,
  parameter int STARVE_MAX = 8
`ifdef REFRESH_EN
  ,
  parameter int TREFI      = 3900,
  parameter int TRFC       = 30
`endif
) (
  input  logic          mem_clk,
  input  logic          rst_n,
  input  logic          rd_mt,
  input  logic [AW-1:0] rd_adrs,
  output logic          rd_pop,
  input  logic          wr_mt,
  input  logic [AW-1:0] wr_adrs,
  output logic          wr_pop,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic          cmd_rw,
  output logic [AW-1:0] cmd_adrs,
  output logic          ref_req,
  output logic          busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int TW = (TURN < 2) ? 1 : $clog2(TURN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_TURN,
    S_REF
  } state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic          last_rw_q, last_rw_d;
  logic [SW-1:0] streak_q, streak_d, streak_nxt;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_rw_q, cmd_rw_d;
  logic [AW-1:0] cmd_adrs_q, cmd_adrs_d;

  logic wr_sel, rd_sel, xfer;
  logic nxt_wr_sel, nxt_rd_sel, dir_change;
  logic rd_pop_c, wr_pop_c;

`ifdef REFRESH_EN
  localparam int RW = (TREFI < 2) ? 1 : $clog2(TREFI);
  localparam int FW = (TRFC < 2) ? 1 : $clog2(TRFC);

  logic [RW-1:0] trefi_cnt_q, trefi_cnt_d;
  logic [FW-1:0] rfc_cnt_q, rfc_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          trefi_wrap, ref_take;

  // A wrap while a refresh is already pending merges into it rather than queueing another.
  always_comb begin
    trefi_wrap  = (trefi_cnt_q == RW'(TREFI - 1));
    trefi_cnt_d = trefi_wrap ? '0 : trefi_cnt_q + RW'(1);
    ref_take    = (state_q == S_IDLE) && ref_pend_q && cmd_ready;
    ref_pend_d  = (ref_pend_q && !ref_take) || trefi_wrap;
  end

  assign ref_req = ref_take && rst_n;
`else
  assign ref_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    last_rw_d   = last_rw_q;
    streak_d    = streak_q;
    turn_cnt_d  = turn_cnt_q;
    cmd_valid_d = cmd_valid_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_adrs_d  = cmd_adrs_q;
`ifdef REFRESH_EN
    rfc_cnt_d   = rfc_cnt_q;
`endif
    rd_pop_c    = 1'b0;
    wr_pop_c    = 1'b0;

    wr_sel = !wr_mt && (rd_mt || (streak_q == SW'(STARVE_MAX)));
    rd_sel = !rd_mt && !wr_sel;
    xfer   = cmd_valid_q && cmd_ready;

    if (!dir_q || wr_mt)
      streak_nxt = '0;
    else if (streak_q == SW'(STARVE_MAX))
      streak_nxt = streak_q;
    else
      streak_nxt = streak_q + SW'(1);

    // Turnaround is judged on the selection IDLE would make right after this transfer.
    nxt_wr_sel = !wr_mt && (rd_mt || (streak_nxt == SW'(STARVE_MAX)));
    nxt_rd_sel = !rd_mt && !nxt_wr_sel;
    dir_change = dir_q ? nxt_wr_sel : nxt_rd_sel;

    case (state_q)
      S_IDLE: begin
`ifdef REFRESH_EN
        if (ref_take) begin
          rfc_cnt_d = FW'(TRFC - 1);
          state_d   = S_REF;
        end else
`endif
        if (cmd_ready && (rd_sel || wr_sel)) begin
          rd_pop_c = rd_sel;
          wr_pop_c = wr_sel;
          dir_d    = rd_sel;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        cmd_adrs_d  = dir_q ? rd_adrs : wr_adrs;
        cmd_rw_d    = dir_q;
        cmd_valid_d = 1'b1;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (xfer) begin
          cmd_valid_d = 1'b0;
          streak_d    = streak_nxt;
          last_rw_d   = dir_q;
          if ((TURN > 0) && dir_change) begin
            turn_cnt_d = TW'(TURN - 1);
            state_d    = S_TURN;
          end else begin
            state_d    = S_IDLE;
          end
        end
      end
      S_TURN: begin
        if (turn_cnt_q == '0)
          state_d = S_IDLE;
        else
          turn_cnt_d = turn_cnt_q - TW'(1);
      end
      S_REF: begin
`ifdef REFRESH_EN
        if (rfc_cnt_q == '0)
          state_d = S_IDLE;
        else
          rfc_cnt_d = rfc_cnt_q - FW'(1);
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      last_rw_q   <= 1'b1;
      streak_q    <= '0;
      turn_cnt_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_adrs_q  <= '0;
`ifdef REFRESH_EN
      trefi_cnt_q <= '0;
      rfc_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      last_rw_q   <= last_rw_d;
      streak_q    <= streak_d;
      turn_cnt_q  <= turn_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_adrs_q  <= cmd_adrs_d;
`ifdef REFRESH_EN
      trefi_cnt_q <= trefi_cnt_d;
      rfc_cnt_q   <= rfc_cnt_d;
      ref_pend_q  <= ref_pend_d;
`endif
    end
  end

  // Pops are decided in IDLE from the live empty flags so the FIFO data lands during FETCH.
  assign rd_pop    = rd_pop_c && rst_n;
  assign wr_pop    = wr_pop_c && rst_n;
  assign cmd_valid = cmd_valid_q;
  assign cmd_rw    = cmd_rw_q;
  assign cmd_adrs  = cmd_adrs_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rw_cmd_arbiter.sv
// Scoreboard bench for rw_cmd_arbiter: emulated address FIFOs, queue-based grant-order model,
// monitor checking payload, pop rules, latency, backpressure hold and turnaround gaps.
`timescale 1ns/1ps
module tb_rw_cmd_arbiter;
  localparam int AW   = 32;
  localparam int TURN = 4;
  localparam int SMAX = 8;
`ifdef REFRESH_EN
  localparam int TREFI = 100;
  localparam int TRFC  = 30;
`endif

  logic          mem_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_mt = 1'b1, wr_mt = 1'b1, cmd_ready = 1'b0;
  logic [AW-1:0] rd_adrs = '0, wr_adrs = '0;
  logic          rd_pop, wr_pop, cmd_valid, cmd_rw, ref_req, busy;
  logic [AW-1:0] cmd_adrs;

  rw_cmd_arbiter #(
    .AW(AW), .TURN(TURN), .STARVE_MAX(SMAX)
`ifdef REFRESH_EN
    , .TREFI(TREFI), .TRFC(TRFC)
`endif
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .rd_mt(rd_mt), .rd_adrs(rd_adrs), .rd_pop(rd_pop),
    .wr_mt(wr_mt), .wr_adrs(wr_adrs), .wr_pop(wr_pop),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_adrs(cmd_adrs),
    .ref_req(ref_req), .busy(busy)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic          rw;
    logic [AW-1:0] adrs;
    int            gap;   // required idle cycles before this command's pop, -1 = unchecked
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] rd_fifo[$];
  logic [AW-1:0] wr_fifo[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  bit            gap_chk = 1'b0;
  int            m_streak = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge mem_clk);
      #1;
    end
  endtask

  // FIFO emulation: data appears the cycle after a pop, junk otherwise.
  initial begin
    bit p_rd, p_wr;
    forever begin
      @(negedge mem_clk);
      p_rd = rd_pop;
      p_wr = wr_pop;
      @(posedge mem_clk);
      #1;
      if (p_rd && rd_fifo.size() > 0) rd_adrs = rd_fifo.pop_front();
      else rd_adrs = $urandom;
      if (p_wr && wr_fifo.size() > 0) wr_adrs = wr_fifo.pop_front();
      else wr_adrs = $urandom;
      rd_mt = (rd_fifo.size() == 0);
      wr_mt = (wr_fifo.size() == 0);
    end
  end

  // Monitor
  initial begin
    bit            pv = 1'b0;
    bit            hold = 1'b0;
    logic [AW:0]   hold_pl = '0;
    int            last_x = -1;
    int            pop_c = -1000;
    int            ref_c = -100000;
    exp_t          e;
    forever begin
      @(negedge mem_clk);
      cyc++;
      if (!rst_n) begin
        pv = 1'b0; hold = 1'b0; last_x = -1; pop_c = -1000;
      end else begin
        check("pop_rules", (rd_pop && wr_pop) || ((rd_pop || wr_pop) && busy) ||
                           (rd_pop && rd_mt) || (wr_pop && wr_mt), 0);
`ifdef REFRESH_EN
        if (ref_req) begin
          check("ref_from_idle", busy, 0);
          ref_c = cyc;
        end
        if (rd_pop || wr_pop) check("ref_quiet", (cyc - ref_c) > TRFC, 1);
`else
        check("ref_req_tied", ref_req, 0);
`endif
        if (hold) check("hold_stable", {cmd_valid, cmd_rw, cmd_adrs}, {1'b1, hold_pl});
        if (rd_pop || wr_pop) begin
          check("pop_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            check("pop_dir", rd_pop, exp_q[0].rw);
            if (gap_chk && last_x >= 0 && exp_q[0].gap >= 0)
              check("turn_gap", cyc - last_x - 1, exp_q[0].gap);
          end
          pop_c = cyc;
        end
        if (cmd_valid && !pv) check("pop_to_valid", cyc - pop_c, 2);
        if (cmd_valid && cmd_ready) begin
          check("cmd_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cmd_payload", {cmd_rw, cmd_adrs}, {e.rw, e.adrs});
          end
          last_x = cyc;
        end
        hold    = cmd_valid && !cmd_ready;
        hold_pl = {cmd_rw, cmd_adrs};
        pv      = cmd_valid;
      end
    end
  end

  task automatic push_one(bit rw, logic [AW-1:0] a, int gap);
    exp_t e;
    e.rw = rw; e.adrs = a; e.gap = gap;
    exp_q.push_back(e);
    if (rw) rd_fifo.push_back(a);
    else    wr_fifo.push_back(a);
  endtask

  // Grant-order model over preloaded contents: reads first unless the starve count is reached.
  task automatic load_phase(int nr, int nw);
    logic [AW-1:0] rq[$];
    logic [AW-1:0] wq[$];
    int r = 0, w = 0;
    bit first = 1'b1, prev = 1'b0;
    for (int i = 0; i < nr; i++) rq.push_back($urandom);
    for (int i = 0; i < nw; i++) wq.push_back($urandom);
    while (r < nr || w < nw) begin
      exp_t e;
      bit ws;
      ws = (w < nw) && (r == nr || m_streak == SMAX);
      if (ws) begin
        e.rw = 1'b0; e.adrs = wq[w]; w++;
        m_streak = 0;
      end else begin
        e.rw = 1'b1; e.adrs = rq[r]; r++;
        m_streak = (w < nw) ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
      end
      e.gap = first ? -1 : ((e.rw != prev) ? TURN : 0);
      first = 1'b0;
      prev  = e.rw;
      exp_q.push_back(e);
    end
    foreach (rq[i]) rd_fifo.push_back(rq[i]);
    foreach (wq[i]) wr_fifo.push_back(wq[i]);
  endtask

  task automatic drain(int budget, bit rnd);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cmd_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    exp_q.delete();
    cmd_ready = 1'b1;
    tick(3);
`ifndef REFRESH_EN
    check("idle_after_drain", {busy, cmd_valid}, 2'b00);
`endif
  endtask

  task automatic wait_pop(int budget);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < budget) begin
      @(negedge mem_clk);
      n++;
      got = rd_pop || wr_pop;
    end
    check("pop_seen", got, 1);
  endtask

  initial begin
    // Reset with a read already waiting: nothing may move until release.
    rst_n = 1'b0;
    cmd_ready = 1'b1;
    m_streak = 0;
    push_one(1'b1, 32'h0000_0040, -1);
    tick(3);
    check("rst_pops", {rd_pop, wr_pop}, 2'b00);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_payload", {cmd_rw, cmd_adrs}, '0);
    check("rst_ref", ref_req, 0);
    rst_n = 1'b1;
    drain(50, 1'b0);

    // Backpressure: five ISSUE cycles with ready low.
    push_one(1'b1, 32'h1234_5678, -1);
    wait_pop(50);
    tick();
    cmd_ready = 1'b0;
    tick(6);
    check("bp_valid_held", {cmd_valid, cmd_rw, cmd_adrs}, {1'b1, 1'b1, 32'h1234_5678});
    cmd_ready = 1'b1;
    drain(50, 1'b0);

    // Reset while a command is stalled in ISSUE drops it.
    push_one(1'b1, 32'hDEAD_BEEF, -1);
    wait_pop(50);
    tick();
    cmd_ready = 1'b0;
    tick(2);
    check("pre_rst_valid", cmd_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    m_streak = 0;
    tick();
    check("midrst_valid", cmd_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pops", {rd_pop, wr_pop}, 2'b00);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    tick(10);
    check("dropped_no_reissue", {busy, cmd_valid}, 2'b00);

    // Write starvation bound: 20 reads + 1 write.
`ifndef REFRESH_EN
    gap_chk = 1'b1;
`endif
    load_phase(20, 1);
    drain(600, 1'b0);

    // Alternating single W/R entries: every change of direction gets the turnaround gap.
    push_one(1'b0, $urandom, -1);
    for (int k = 0; k < 6; k++) begin
      wait_pop(60);
      push_one(k[0] ? 1'b0 : 1'b1, $urandom, TURN);
    end
    drain(100, 1'b0);
    m_streak = 0;

    // Same-direction streams and mixes with held-high ready.
    load_phase(5, 0);
    drain(200, 1'b0);
    load_phase(0, 5);
    drain(200, 1'b0);
    load_phase(10, 4);
    drain(400, 1'b0);
    gap_chk = 1'b0;

    // Randomized mixes with random backpressure.
    for (int rnd = 0; rnd < 10; rnd++) begin
      load_phase($urandom_range(0, 14), $urandom_range(0, 8));
      drain(1500, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
